pea_stream_fifo: RTL and testbench

- Next-generation dataflow FIFO for the PEA actor edges (data, command, result and status queues).
- Generalised in depth and width, with occupancy counters wide enough to report a completely full buffer.
- Adds almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Sits between the bench or upstream actors and PEA_top_module_1; PEA_enable consumes population and free_space.

---
 rtl/pea_stream_fifo.sv | 109 ++++++++++
 tb/tb_pea_stream_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_stream_fifo.sv
// Parameterised stream FIFO for PEA actor edges with occupancy counters, threshold flags,
// synchronous flush and sticky error flags. Define PEA_FIFO_FWFT_EN for first-word-fall-through reads.
module pea_stream_fifo #(
  parameter int BUFFER_SIZE = 1024,
  parameter int WIDTH       = 16,
  parameter int AF_MARGIN   = 4,
  parameter int AE_MARGIN   = 4,
  localparam int AW = $clog2(BUFFER_SIZE),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [PW-1:0]    population,
  output logic [PW-1:0]    free_space,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  // Margins beyond the depth would truncate in PW bits; clamp so the flags stay meaningful.
  localparam int AF_C = (AF_MARGIN > BUFFER_SIZE) ? BUFFER_SIZE : AF_MARGIN;
  localparam int AE_C = (AE_MARGIN > BUFFER_SIZE) ? BUFFER_SIZE : AE_MARGIN;
  localparam logic [PW-1:0] DEPTH  = PW'(BUFFER_SIZE);
  localparam logic [PW-1:0] AF_LIM = PW'(AF_C);
  localparam logic [PW-1:0] AE_LIM = PW'(AE_C);

  logic [WIDTH-1:0] mem [BUFFER_SIZE];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [PW-1:0]    count;
  logic             has_data;
  logic             has_room;
  logic             wr_ok;
  logic             rd_ok;
  logic             wr_bad;
  logic             rd_bad;

  assign has_data = (count != '0);
  assign has_room = (count != DEPTH);

  // A write into a full buffer is still accepted when a read frees a slot on the same edge.
  assign wr_ok  = wr_en & ~flush & (has_room | (rd_en & has_data));
  assign rd_ok  = rd_en & ~flush & has_data;
  assign wr_bad = wr_en & ~flush & ~wr_ok;
  assign rd_bad = rd_en & ~flush & ~has_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  // A new error on the same edge as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_bad | (overflow & ~clr_err);
      underflow <= rd_bad | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

`ifdef PEA_FIFO_FWFT_EN
  assign data_out = has_data ? mem[rd_ptr] : '0;
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       dout_q <= '0;
    else if (flush) dout_q <= '0;
    else if (rd_ok) dout_q <= mem[rd_ptr];
  end

  assign data_out = dout_q;
`endif

  assign population   = count;
  assign free_space   = DEPTH - count;
  assign full         = (count == DEPTH);
  assign empty        = ~has_data;
  assign almost_full  = (free_space <= AF_LIM);
  assign almost_empty = (count <= AE_LIM);

endmodule

// File: tb/tb_pea_stream_fifo.sv
// Bench for pea_stream_fifo (depth 8): queue-based reference model checked every cycle,
// plus directed literal expectations for the reset, full/empty, wrap, flush and reset-abort cases.
module tb_pea_stream_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic [3:0]    population;
  logic [3:0]    free_space;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int vectors = 0;
  int miscompares = 0;

  pea_stream_fifo #(
    .BUFFER_SIZE(DEPTH),
    .WIDTH(W),
    .AF_MARGIN(2),
    .AE_MARGIN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .flush(flush),
    .clr_err(clr_err),
    .data_in(data_in),
    .data_out(data_out),
    .population(population),
    .free_space(free_space),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of stored words.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ov = 1'b0;
  logic         m_uf = 1'b0;
  int           m_sz;
  bit           m_wok;
  bit           m_rok;
  logic [W-1:0] m_tmp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_dout = '0;
      m_ov = 1'b0;
      m_uf = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_rok = rd_en && !flush && m_sz > 0;
      m_wok = wr_en && !flush && (m_sz < DEPTH || (rd_en && m_sz > 0));
      if (wr_en && !flush && !m_wok) m_ov = 1'b1;
      else if (clr_err)              m_ov = 1'b0;
      if (rd_en && !flush && m_sz == 0) m_uf = 1'b1;
      else if (clr_err)                 m_uf = 1'b0;
      if (flush) begin
        mq.delete();
        m_dout = '0;
      end else begin
        if (m_rok) begin
          m_tmp = mq.pop_front();
          m_dout = m_tmp;
        end
        if (m_wok) mq.push_back(data_in);
      end
    end
  end

  function automatic logic [W-1:0] exp_dout();
`ifdef PEA_FIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  bit run_checks = 0;

  always @(negedge clk) begin
    if (run_checks) begin
      check("population",   32'(population),   32'(mq.size()));
      check("free_space",   32'(free_space),   32'(DEPTH - mq.size()));
      check("full",         32'(full),         32'(mq.size() == DEPTH));
      check("empty",        32'(empty),        32'(mq.size() == 0));
      check("almost_full",  32'(almost_full),  32'((DEPTH - mq.size()) <= 2));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
      check("overflow",     32'(overflow),     32'(m_ov));
      check("underflow",    32'(underflow),    32'(m_uf));
      check("data_out",     32'(data_out),     32'(exp_dout()));
    end
  end

  task automatic step(input logic w, input logic r, input logic f, input logic c, input logic [W-1:0] d);
    wr_en = w; rd_en = r; flush = f; clr_err = c; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic pop();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_population", 32'(population), 32'd0);
    check("rst_free_space", 32'(free_space), 32'd8);
    check("rst_empty",      32'(empty),      32'd1);
    check("rst_full",       32'(full),       32'd0);
    check("rst_ae",         32'(almost_empty), 32'd1);
    check("rst_af",         32'(almost_full),  32'd0);
    check("rst_dout",       32'(data_out),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_checks = 1;

`ifdef PEA_FIFO_FWFT_EN
    push(16'h1234);
    check("fwft_dout_after_write", 32'(data_out), 32'h1234);
    idle();
    check("fwft_dout_hold", 32'(data_out), 32'h1234);
    pop();
    check("fwft_dout_after_ack", 32'(data_out), 32'd0);
    check("fwft_empty", 32'(empty), 32'd1);
`endif

    // Fill to full, then one refused push.
    for (int i = 1; i <= 8; i++) begin
      push(W'(i));
      check("fill_af", 32'(almost_full), 32'(i >= 6));
    end
    check("fill_population", 32'(population), 32'd8);
    check("fill_free_space", 32'(free_space), 32'd0);
    check("fill_full",       32'(full),       32'd1);
    check("fill_overflow",   32'(overflow),   32'd0);
    push(16'hDEAD);
    check("ovf_population", 32'(population), 32'd8);
    check("ovf_overflow",   32'(overflow),   32'd1);

    // Drain in order, then one refused pop.
    for (int i = 1; i <= 8; i++) begin
      pop();
`ifndef PEA_FIFO_FWFT_EN
      check("drain_dout", 32'(data_out), 32'(i));
`endif
    end
    check("drain_empty", 32'(empty), 32'd1);
    pop();
    check("udf_underflow", 32'(underflow), 32'd1);
`ifndef PEA_FIFO_FWFT_EN
    check("udf_dout_hold", 32'(data_out), 32'h0008);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("clr_overflow",  32'(overflow),  32'd0);
    check("clr_underflow", 32'(underflow), 32'd0);

    // Pointer wrap-around.
    for (int i = 0; i < 6; i++) push(W'(16'h0010 + i));
    for (int i = 0; i < 6; i++) pop();
    for (int i = 0; i < 8; i++) push(W'(16'h00A0 + i));
    check("wrap_population", 32'(population), 32'd8);
    for (int i = 0; i < 8; i++) begin
      pop();
`ifndef PEA_FIFO_FWFT_EN
      check("wrap_dout", 32'(data_out), 32'(16'h00A0 + i));
`endif
    end

    // Simultaneous read/write when full, then when empty.
    for (int i = 0; i < 8; i++) push(W'(16'h0030 + i));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, W'(16'h0040 + i));
      check("rw_full_population", 32'(population), 32'd8);
      check("rw_full_overflow",   32'(overflow),   32'd0);
`ifndef PEA_FIFO_FWFT_EN
      check("rw_full_dout", 32'(data_out), 32'(16'h0030 + i));
`endif
    end
    for (int i = 0; i < 8; i++) pop();
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0055);
    check("rw_empty_population", 32'(population), 32'd1);
    check("rw_empty_underflow",  32'(underflow),  32'd1);
    pop();
`ifndef PEA_FIFO_FWFT_EN
    check("rw_empty_dout", 32'(data_out), 32'h0055);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Flush with a coincident write.
    for (int i = 0; i < 5; i++) push(W'(16'h0070 + i));
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0077);
    check("flush_population", 32'(population), 32'd0);
    check("flush_dout",       32'(data_out),   32'd0);
    check("flush_empty",      32'(empty),      32'd1);
    check("flush_overflow",   32'(overflow),   32'd0);
    push(16'h0078);
    pop();
`ifndef PEA_FIFO_FWFT_EN
    check("post_flush_dout", 32'(data_out), 32'h0078);
`endif

    // Asynchronous reset in the middle of a burst.
    push(16'h0061);
    push(16'h0062);
    wr_en = 1'b1; data_in = 16'h0063;
    #3;
    rst = 1'b0;
    #1;
    check("arst_population", 32'(population), 32'd0);
    check("arst_free_space", 32'(free_space), 32'd8);
    check("arst_empty",      32'(empty),      32'd1);
    check("arst_dout",       32'(data_out),   32'd0);
    wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    push(16'h0099);
    check("post_rst_population", 32'(population), 32'd1);
    idle();
    idle();

    run_checks = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
